// File: rtl/deser_trama_if.sv
// Handshake bundle between the frame receiver and its neighbours:
// serial input side (from det_sec) and parallel word output side (to consumer).
interface deser_trama_if #(
  parameter int WIDTH = 8
);
  logic             s_in;
  logic             sync_in;
  logic [WIDTH-1:0] dato_out;
  logic             dato_valido;
  logic             dato_listo;
  logic             desborde;
  logic             err_paridad;

  // Receiver side: consumes the serial stream, produces words.
  modport slave (
    input  s_in,
    input  sync_in,
    input  dato_listo,
    output dato_out,
    output dato_valido,
    output desborde,
    output err_paridad
  );

  // Driver/consumer side: feeds the serial stream, takes words.
  modport master (
    output s_in,
    output sync_in,
    output dato_listo,
    input  dato_out,
    input  dato_valido,
    input  desborde,
    input  err_paridad
  );
endinterface

// File: rtl/deser_trama.sv
// deser_trama: serial-to-parallel frame receiver behind det_sec.
// Assembles s_in MSB-first into WIDTH-bit words while sync_in is high and
// queues them in a FIFO_DEPTH-entry FIFO with a valid/ready output.
// Optional build macro DESER_PARIDAD_EN: every word is followed by an
// even-parity bit; bad words are dropped and err_paridad pulses.
//
// state   | meaning
// ESPERA  | idle, waiting for sync_in to start a word
// RECIBE  | shifting word bits in, MSB first
// PARIDAD | sampling the parity bit after a full word (macro only)
module deser_trama #(
  parameter int WIDTH      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input logic           clk,
  input logic           rst,
  deser_trama_if.slave  bus_if
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(WIDTH);

`ifdef DESER_PARIDAD_EN
  typedef enum logic [2:0] {
    ESPERA  = 3'b001,
    RECIBE  = 3'b010,
    PARIDAD = 3'b100
  } state_t;
`else
  typedef enum logic [1:0] {
    ESPERA = 2'b01,
    RECIBE = 2'b10
  } state_t;
`endif

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] shift_next;
  logic [WIDTH-1:0] push_word;
  logic             push;

`ifdef DESER_PARIDAD_EN
  logic             err_q, err_d;
`endif

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      count_q;
  logic             desborde_q;
  logic             empty, full, pop, push_ok;

  // FSM state, bit counter and shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ESPERA;
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

`ifdef DESER_PARIDAD_EN
  // Parity error pulse register, one cycle after the bad parity bit.
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end
`endif

  // Next-state logic: word assembly, completion and push request.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    shift_next = {shift_q[WIDTH-2:0], bus_if.s_in};
    push_word  = shift_next;
    push       = 1'b0;
`ifdef DESER_PARIDAD_EN
    err_d      = 1'b0;
`endif
    case (state_q)
      ESPERA: begin
        if (bus_if.sync_in) begin
          shift_d = {{(WIDTH-1){1'b0}}, bus_if.s_in};
          cnt_d   = CW'(1);
          state_d = RECIBE;
        end
      end
      RECIBE: begin
        // Losing sync beats word completion: the partial word is discarded.
        if (!bus_if.sync_in) begin
          cnt_d   = '0;
          state_d = ESPERA;
        end else begin
          shift_d = shift_next;
          if (cnt_q == CW'(WIDTH-1)) begin
            cnt_d = '0;
`ifdef DESER_PARIDAD_EN
            state_d = PARIDAD;
`else
            push    = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
`ifdef DESER_PARIDAD_EN
      PARIDAD: begin
        cnt_d = '0;
        if (!bus_if.sync_in) begin
          state_d = ESPERA;
        end else begin
          state_d = RECIBE;
          if (^{shift_q, bus_if.s_in}) begin
            err_d = 1'b1;
          end else begin
            push      = 1'b1;
            push_word = shift_q;
          end
        end
      end
`endif
      default: begin
        cnt_d   = '0;
        state_d = ESPERA;
      end
    endcase
  end

  // FIFO handshake decode; a push into a full FIFO still lands if a pop
  // frees a slot in the same cycle.
  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == (AW+1)'(FIFO_DEPTH));
    pop     = !empty && bus_if.dato_listo;
    push_ok = push && (!full || pop);
  end

  // FIFO storage; contents are only observable through count, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= push_word;
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q       <= '0;
      rd_q       <= '0;
      count_q    <= '0;
      desborde_q <= 1'b0;
    end else begin
      if (push_ok) wr_q <= wr_q + AW'(1);
      if (pop)     rd_q <= rd_q + AW'(1);
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
      if (push && !push_ok) desborde_q <= 1'b1;
    end
  end

  // Outputs; the word is forced to zero while the FIFO is empty.
  always_comb begin
    bus_if.dato_valido = !empty;
    bus_if.dato_out    = empty ? '0 : mem_q[rd_q];
    bus_if.desborde    = desborde_q;
`ifdef DESER_PARIDAD_EN
    bus_if.err_paridad = err_q;
`else
    bus_if.err_paridad = 1'b0;
`endif
  end

endmodule

// File: tb/tb_deser_trama.sv
// Self-checking bench for deser_trama (WIDTH=8, FIFO_DEPTH=4).
// Follows DESER_PARIDAD_EN when the same macro is given to the build.
module tb_deser_trama;

`ifdef DESER_PARIDAD_EN
  localparam bit PAR   = 1'b1;
  localparam int FRAME = 9;
`else
  localparam bit PAR   = 1'b0;
  localparam int FRAME = 8;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  deser_trama_if #(.WIDTH(8)) bus_if ();

  deser_trama #(.WIDTH(8), .FIFO_DEPTH(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bus_if)
  );

  int n_checks   = 0;
  int n_fail     = 0;
  int cyc        = 0;
  int err_pulses = 0;
  logic [7:0] got_q[$];
  int         got_cyc[$];

  typedef struct {
    logic [7:0] word;
    logic       flip;
    int         exp_cnt;
    logic [7:0] exp_word;
    int         exp_err;
  } vec_t;
  vec_t vecs[7];

  // Record every accepted word and parity pulse, sampled mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (!rst && bus_if.dato_valido && bus_if.dato_listo) begin
      got_q.push_back(bus_if.dato_out);
      got_cyc.push_back(cyc);
    end
    if (!rst && bus_if.err_paridad) err_pulses++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_log();
    got_q.delete();
    got_cyc.delete();
    err_pulses = 0;
  endtask

  task automatic idle(input int n);
    bus_if.sync_in = 1'b0;
    bus_if.s_in    = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    bus_if.sync_in = 1'b0;
    bus_if.s_in    = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Send one word MSB-first, plus its parity bit when parity is built in.
  task automatic send_word(input logic [7:0] w, input logic flip);
    for (int i = 7; i >= 0; i--) begin
      bus_if.sync_in = 1'b1;
      bus_if.s_in    = w[i];
      tick();
    end
    if (PAR) begin
      bus_if.s_in = (^w) ^ flip;
      tick();
    end
  endtask

  initial begin
    rst               = 1'b1;
    bus_if.sync_in    = 1'b0;
    bus_if.s_in       = 1'b0;
    bus_if.dato_listo = 1'b0;

    vecs[0] = '{8'hA5, 1'b0, 1, 8'hA5, 0};
    vecs[1] = '{8'h3C, 1'b0, 1, 8'h3C, 0};
    vecs[2] = '{8'hFF, 1'b0, 1, 8'hFF, 0};
    vecs[3] = '{8'h00, 1'b0, 1, 8'h00, 0};
    vecs[4] = '{8'h81, 1'b0, 1, 8'h81, 0};
    vecs[5] = '{8'hA5, 1'b1, PAR ? 0 : 1, 8'hA5, PAR ? 1 : 0};
    vecs[6] = '{8'h01, 1'b1, PAR ? 0 : 1, 8'h01, PAR ? 1 : 0};

    do_reset();
    chk("rst_valido",   32'(bus_if.dato_valido), 0);
    chk("rst_dato",     32'(bus_if.dato_out), 0);
    chk("rst_desborde", 32'(bus_if.desborde), 0);
    chk("rst_err",      32'(bus_if.err_paridad), 0);

    // Table: one frame each, consumer always ready.
    bus_if.dato_listo = 1'b1;
    for (int v = 0; v < 7; v++) begin
      clear_log();
      send_word(vecs[v].word, vecs[v].flip);
      idle(3);
      chk("vec_count", got_q.size(), vecs[v].exp_cnt);
      if (got_q.size() > 0) chk("vec_word", 32'(got_q[0]), 32'(vecs[v].exp_word));
      chk("vec_err", err_pulses, vecs[v].exp_err);
    end

    // 0xA5: valid exactly one cycle, starting the cycle after the last bit.
    clear_log();
    send_word(8'hA5, 1'b0);
    chk("lat_valido", 32'(bus_if.dato_valido), 1);
    chk("lat_dato",   32'(bus_if.dato_out), 32'h A5);
    idle(1);
    chk("lat_valido_off", 32'(bus_if.dato_valido), 0);
    idle(2);
    chk("lat_count", got_q.size(), 1);

    // Back-to-back words under continuous sync.
    clear_log();
    send_word(8'h3C, 1'b0);
    send_word(8'hF0, 1'b0);
    idle(3);
    chk("b2b_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("b2b_first",  32'(got_q[0]), 32'h3C);
      chk("b2b_second", 32'(got_q[1]), 32'hF0);
      chk("b2b_spacing", got_cyc[1] - got_cyc[0], FRAME);
    end

    // Overflow: five words into a stalled four-entry FIFO.
    do_reset();
    clear_log();
    bus_if.dato_listo = 1'b0;
    for (int w = 1; w <= 5; w++) send_word(8'(w), 1'b0);
    chk("ovf_desborde", 32'(bus_if.desborde), 1);
    idle(2);
    chk("ovf_hold_valido", 32'(bus_if.dato_valido), 1);
    chk("ovf_hold_dato",   32'(bus_if.dato_out), 1);
    bus_if.dato_listo = 1'b1;
    idle(6);
    chk("ovf_drain_count", got_q.size(), 4);
    for (int i = 0; i < got_q.size() && i < 4; i++) chk("ovf_drain_word", 32'(got_q[i]), i + 1);
    chk("ovf_empty",    32'(bus_if.dato_valido), 0);
    chk("ovf_sticky",   32'(bus_if.desborde), 1);
    do_reset();
    chk("ovf_rst_desborde", 32'(bus_if.desborde), 0);

    // Sync lost after five bits, then a clean 0x77.
    clear_log();
    for (int i = 0; i < 5; i++) begin
      bus_if.sync_in = 1'b1;
      bus_if.s_in    = 1'b1;
      tick();
    end
    idle(2);
    send_word(8'h77, 1'b0);
    idle(3);
    chk("resync_count", got_q.size(), 1);
    if (got_q.size() > 0) chk("resync_word", 32'(got_q[0]), 32'h77);

    // Reset during bit 4 with two words queued.
    bus_if.dato_listo = 1'b0;
    send_word(8'h11, 1'b0);
    send_word(8'h22, 1'b0);
    chk("mid_queued", 32'(bus_if.dato_valido), 1);
    for (int i = 0; i < 3; i++) begin
      bus_if.sync_in = 1'b1;
      bus_if.s_in    = 1'b1;
      tick();
    end
    rst = 1'b1;
    tick();
    chk("mid_rst_valido",   32'(bus_if.dato_valido), 0);
    chk("mid_rst_desborde", 32'(bus_if.desborde), 0);
    chk("mid_rst_dato",     32'(bus_if.dato_out), 0);
    rst = 1'b0;
    idle(1);
    clear_log();
    bus_if.dato_listo = 1'b1;
    send_word(8'h5A, 1'b0);
    idle(3);
    chk("post_rst_count", got_q.size(), 1);
    if (got_q.size() > 0) chk("post_rst_word", 32'(got_q[0]), 32'h5A);

    // Bad parity: one-cycle pulse and no word (no pulse, word kept if off).
    clear_log();
    send_word(8'hA5, 1'b1);
    chk("par_err_pulse", 32'(bus_if.err_paridad), PAR ? 1 : 0);
    chk("par_valido",    32'(bus_if.dato_valido), PAR ? 0 : 1);
    idle(1);
    chk("par_err_off",   32'(bus_if.err_paridad), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
